// File: rtl/adder_16bit.sv
// adder_16bit: 16-bit two's-complement carry-lookahead adder.
//
// The sum on `out` is purely combinational. Four 4-bit lookahead groups
// feed a second-level lookahead unit that resolves the group carry-ins
// (c4, c8, c12) and the final carry out (c16).
//
// Build option ADDER16_FLAGS_EN:
//   defined   - `outReg` plus registered carry/overflow/zero/negative,
//               captured on every rising clk edge, cleared by `reset`.
//   undefined - no flip-flops; those outputs are tied to 0.
// `out` and the port list are the same in both builds.

// 4-bit lookahead group: carries into each of its bits plus group G/P.
module adder_16bit_cla4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] c,
    output logic       gg,
    output logic       pg
);

    // Flattened lookahead equations, so no carry ripples through the group.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
    end

endmodule

// Second-level lookahead: carry into each group and the final carry out.
module adder_16bit_lcu (
    input  logic [3:0] gg,
    input  logic [3:0] pg,
    input  logic       cin,
    output logic [4:1] cg
);

    // cg[k] is the carry into bit 4*k; cg[4] is the carry out of bit 15.
    always_comb begin
        cg[1] = gg[0] | (pg[0] & cin);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
              | (pg[2] & pg[1] & pg[0] & cin);
        cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
              | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    end

endmodule

module adder_16bit (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] aIn,
    input  logic [15:0] bIn,
    output logic [15:0] out,
    output logic [15:0] outReg,
    output logic        carry,
    output logic        overflow,
    output logic        zero,
    output logic        negative
);

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:1]  grp_c;
    logic [3:0]  grp_cin;
    logic        c16;

    assign g = aIn & bIn;
    assign p = aIn ^ bIn;

    // The adder has no external carry-in; group 0 always starts from 0.
    assign grp_cin = {grp_c[3:1], 1'b0};

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : gen_grp
            adder_16bit_cla4 u_cla4 (
                .g   (g[4*k +: 4]),
                .p   (p[4*k +: 4]),
                .cin (grp_cin[k]),
                .c   (c[4*k +: 4]),
                .gg  (grp_g[k]),
                .pg  (grp_p[k])
            );
        end
    endgenerate

    adder_16bit_lcu u_lcu (
        .gg  (grp_g),
        .pg  (grp_p),
        .cin (1'b0),
        .cg  (grp_c)
    );

    assign c16 = grp_c[4];
    assign out = p ^ c;

`ifdef ADDER16_FLAGS_EN

    // Capture the sum and its status flags one cycle behind the inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outReg   <= 16'h0000;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else begin
            outReg   <= out;
            carry    <= c16;
            overflow <= (aIn[15] == bIn[15]) && (out[15] != aIn[15]);
            zero     <= (out == 16'h0000);
            negative <= out[15];
        end
    end

`else

    assign outReg   = 16'h0000;
    assign carry    = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
    assign negative = 1'b0;

    // clk, reset and the final carry only feed the registers in this build.
    logic unused_regs_in;
    assign unused_regs_in = &{1'b0, clk, reset, c16};

`endif

endmodule

// File: tb/tb_adder_16bit.sv
// Bench for adder_16bit; expectations for the registered outputs follow
// whichever way ADDER16_FLAGS_EN is set for the build.
module tb_adder_16bit;

    logic        clk;
    logic        reset;
    logic [15:0] aIn;
    logic [15:0] bIn;
    logic [15:0] out;
    logic [15:0] outReg;
    logic        carry;
    logic        overflow;
    logic        zero;
    logic        negative;

    int vectors     = 0;
    int miscompares = 0;

`ifdef ADDER16_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] sum;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    exp_t sb_q[$];

    adder_16bit dut (
        .clk      (clk),
        .reset    (reset),
        .aIn      (aIn),
        .bIn      (bIn),
        .out      (out),
        .outReg   (outReg),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] t;
        int          s;
        t   = {1'b0, a} + {1'b0, b};
        s   = int'($signed(a)) + int'($signed(b));
        e.sum = t[15:0];
        e.c   = t[16];
        e.v   = (s > 32767) || (s < -32768);
        e.z   = (t[15:0] == 16'h0000);
        e.n   = t[15];
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b);
        aIn = a;
        bIn = b;
        sb_q.push_back(model(a, b));
    endtask

    task automatic pop_exp(input string tag, output exp_t e);
        check_val({tag, "_pending"}, 16'(sb_q.size() != 0), 16'd1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        else e = '0;
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check_val({tag, "_outReg"},   outReg,        FLAGS ? e.sum : 16'h0);
        check_val({tag, "_carry"},    16'(carry),    16'(FLAGS & e.c));
        check_val({tag, "_overflow"}, 16'(overflow), 16'(FLAGS & e.v));
        check_val({tag, "_zero"},     16'(zero),     16'(FLAGS & e.z));
        check_val({tag, "_negative"}, 16'(negative), 16'(FLAGS & e.n));
    endtask

    task automatic comb_step(input string tag, input logic [15:0] a,
                             input logic [15:0] b);
        exp_t e;
        @(negedge clk);
        drive(a, b);
        #2;
        pop_exp(tag, e);
        check_val({tag, "_out"}, out, e.sum);
    endtask

    task automatic reg_step(input string tag, input logic [15:0] a,
                            input logic [15:0] b, output exp_t e);
        @(negedge clk);
        drive(a, b);
        @(posedge clk);
        #1;
        pop_exp(tag, e);
        check_val({tag, "_out"}, out, e.sum);
        check_regs(tag, e);
    endtask

    initial begin
        exp_t e;
        exp_t held;
        exp_t zero_e;
        zero_e = '0;

        reset = 1'b1;
        aIn   = 16'h0000;
        bIn   = 16'h0000;
        sb_q.push_back(model(16'h0000, 16'h0000));
        #50;
        pop_exp("rst", e);
        check_val("rst_out", out, e.sum);
        check_regs("rst", zero_e);
        #50;
        reset = 1'b0;

        comb_step("c15p15",  16'd15,   16'd15);
        comb_step("c0p67",   16'd0,    16'd67);
        comb_step("c15p0",   16'd15,   16'd0);
        comb_step("cm5p12",  16'hFFFB, 16'd12);
        comb_step("c15pm15", 16'd15,   16'hFFF1);
        comb_step("calt",    16'hAAAA, 16'h5555);
        comb_step("cprop",   16'h0FFF, 16'h0001);

        reg_step("wrap", 16'hFFFF, 16'h0001, e);
        reg_step("ovf",  16'h7FFF, 16'h0001, e);
        reg_step("neg2", 16'h8000, 16'h8000, e);

        // Registered copy must hold between edges while out follows inputs.
        reg_step("hold", 16'h1234, 16'h4321, held);
        #1;
        drive(16'h0F0F, 16'h00F1);
        #1;
        pop_exp("hold_new", e);
        check_val("hold_new_out", out, e.sum);
        check_regs("hold_keep", held);

        // Asynchronous reset between edges after a nonzero capture.
        reg_step("pre_rst", 16'h2000, 16'h0345, e);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_regs("arst", zero_e);
        drive(16'h00F0, 16'h0F00);
        #1;
        pop_exp("arst_trk", e);
        check_val("arst_trk_out", out, e.sum);
        @(posedge clk);
        #1;
        check_regs("arst_edge", zero_e);
        @(negedge clk);
        reset = 1'b0;
        reg_step("first_cap", 16'h0000, 16'h0000, e);

        for (int i = 0; i < 24; i++) begin
            reg_step($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), e);
        end

        check_val("sbq_drained", 16'(sb_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_16bit.md
# adder_16bit

Sixteen-bit two's-complement adder for the processor datapath, used for PC increment, branch-target and address arithmetic. The `out` sum is purely combinational with zero latency. The block also provides a one-cycle registered copy of the sum and registered status flags (carry, overflow, zero, negative) for the control unit. The adder is built from four 4-bit carry-lookahead groups plus a second-level lookahead unit.

## Interface
Parameters:
- none; width fixed at 16 bits.

Ports:
- `clk`  input  1  single clock; all registers update on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all registered outputs.
- `aIn`  input  16  operand A, unsigned or two's complement.
- `bIn`  input  16  operand B, unsigned or two's complement.
- `out`  output  16  combinational sum, (aIn + bIn) mod 2^16.
- `outReg`  output  16  `out` registered on `clk`.
- `carry`  output  1  registered carry out of bit 15.
- `overflow`  output  1  registered signed overflow.
- `zero`  output  1  registered: sum == 0.
- `negative`  output  1  registered: sum bit 15.

## Operation
- Per-bit signals: generate g[i] = aIn[i] & bIn[i]; propagate p[i] = aIn[i] ^ bIn[i].
- Four 4-bit lookahead groups (bits 3:0, 7:4, 11:8, 15:12):
  - each group produces internal carries, group generate G and group propagate P;
  - carry-in of group 0 is constant 0.
- Second-level lookahead unit computes group carry-ins c4, c8, c12 and c16 from G/P.
- Sum: out[i] = p[i] ^ c[i].
- carry = c16.
- overflow = (aIn[15] == bIn[15]) && (out[15] != aIn[15]).
- zero = (out == 16'h0000); negative = out[15].
- Signedness: identical bit pattern for signed and unsigned operands; interpretation is the consumer's choice.
- Wrap-around: 16'hFFFF + 16'h0001 gives out = 0, carry = 1, zero = 1, overflow = 0.
- Signed overflow: 16'h7FFF + 16'h0001 gives out = 16'h8000, overflow = 1, negative = 1, carry = 0.
- No internal state other than the output registers; no handshake; every cycle is valid.

## Timing
- `out`: combinational, zero latency; settles within one gate-delay path after any input change. It does not depend on `clk` or `reset`.
- `outReg`, `carry`, `overflow`, `zero`, `negative`:
  - capture the current combinational results on each rising `clk` edge (latency 1 cycle);
  - while `reset` is high, all are held at 0 (including `zero` = 0) regardless of `clk`;
  - reset assertion mid-operation clears them immediately;
  - the first capture occurs on the first rising edge after `reset` deasserts.
- Inputs changing in the same cycle as the edge: the values present at the edge are the ones captured.

## Configuration
- Macro `ADDER16_FLAGS_EN`:
  - Defined: `outReg` and the four flag registers and logic are present as described above.
  - Undefined: no flip-flops are instantiated; `outReg`, `carry`, `overflow`, `zero` and `negative` are tied to constant 0.
  - `out` behaviour is identical in both builds; the port list is unchanged.

## Test plan
- Hold reset 100 ns, then apply combinational vectors, 10 ns apart, and check `out`:
  - 15 + 15 -> 30;
  - 0 + 67 -> 67;
  - 15 + 0 -> 15;
  - 16'hFFFB (−5) + 12 -> 7;
  - 15 + 16'hFFF1 (−15) -> 0.
- Apply 16'hFFFF + 16'h0001, then one clock edge -> out = 0, outReg = 0, carry = 1, zero = 1, overflow = 0.
- Apply 16'h7FFF + 16'h0001, then one edge -> outReg = 16'h8000, overflow = 1, negative = 1, carry = 0.
- Apply 16'h8000 + 16'h8000, then one edge -> outReg = 0, carry = 1, overflow = 1, zero = 1.
- Assert reset asynchronously between clock edges after a nonzero capture -> all registered outputs go to 0 immediately while `out` still tracks inputs.
- Build without `ADDER16_FLAGS_EN` and rerun the first scenario -> same `out` values; flags and `outReg` stay 0.
